// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU merging an arith/logic unit and a shift unit.
// Optional macro ALU_SAT_EN: signed ADD/SUB saturate on overflow (flag_ovf marks saturation).
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] aluin1,
  input  logic [WIDTH-1:0] aluin2,
  input  logic             unit_sel,
  input  logic [2:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             err_illegal,
  output logic [CNT_W-1:0] op_count
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_SLT  = 3'd6;
  localparam logic [2:0] OP_SLTU = 3'd7;

  localparam logic [2:0] OP_SLL  = 3'd0;
  localparam logic [2:0] OP_SRL  = 3'd1;
  localparam logic [2:0] OP_SRA  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;

  // Stage 1: captured operands
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic             s1_unit_reg;
  logic [2:0]       s1_op_reg;

  // Stage 2: registered result, drives the outputs directly
  logic             s2_valid_reg;
  logic [WIDTH-1:0] s2_res_reg;
  logic             s2_zero_reg;
  logic             s2_carry_reg;
  logic             s2_ovf_reg;
  logic             s2_ill_reg;
  logic [CNT_W-1:0] op_count_reg;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  // ---------------- arith/logic unit ----------------
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] arith_res;
  logic             arith_carry;
  logic             arith_ovf;

  assign add_ext = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
  assign sub_ext = {1'b0, s1_a_reg} - {1'b0, s1_b_reg};
  assign add_ovf = (s1_a_reg[WIDTH-1] == s1_b_reg[WIDTH-1]) &&
                   (add_ext[WIDTH-1] != s1_a_reg[WIDTH-1]);
  assign sub_ovf = (s1_a_reg[WIDTH-1] != s1_b_reg[WIDTH-1]) &&
                   (sub_ext[WIDTH-1] != s1_a_reg[WIDTH-1]);

`ifdef ALU_SAT_EN
  // Overflow direction always follows the sign of A for both ADD and SUB
  logic [WIDTH-1:0] sat_val;
  assign sat_val = s1_a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
`endif

  always_comb begin
    arith_res   = '0;
    arith_carry = 1'b0;
    arith_ovf   = 1'b0;
    case (s1_op_reg)
      OP_ADD: begin
`ifdef ALU_SAT_EN
        arith_res = add_ovf ? sat_val : add_ext[WIDTH-1:0];
`else
        arith_res = add_ext[WIDTH-1:0];
`endif
        arith_carry = add_ext[WIDTH];
        arith_ovf   = add_ovf;
      end
      OP_SUB: begin
`ifdef ALU_SAT_EN
        arith_res = sub_ovf ? sat_val : sub_ext[WIDTH-1:0];
`else
        arith_res = sub_ext[WIDTH-1:0];
`endif
        arith_carry = sub_ext[WIDTH];
        arith_ovf   = sub_ovf;
      end
      OP_AND:  arith_res = s1_a_reg & s1_b_reg;
      OP_OR:   arith_res = s1_a_reg | s1_b_reg;
      OP_XOR:  arith_res = s1_a_reg ^ s1_b_reg;
      OP_NOR:  arith_res = ~(s1_a_reg | s1_b_reg);
      OP_SLT:  arith_res = {{(WIDTH-1){1'b0}}, $signed(s1_a_reg) < $signed(s1_b_reg)};
      OP_SLTU: arith_res = {{(WIDTH-1){1'b0}}, s1_a_reg < s1_b_reg};
      default: arith_res = '0;
    endcase
  end

  // ---------------- shift unit ----------------
  logic [SHW-1:0]   sh;
  logic [SHW-1:0]   sh_dec;
  logic [SHW-1:0]   sh_neg;
  logic [SHW:0]     sh_comp;
  logic             sh_nz;
  logic [WIDTH-1:0] shift_res;
  logic             shift_carry;
  logic             shift_ill;

  assign sh      = s1_b_reg[SHW-1:0];
  assign sh_nz   = (sh != '0);
  assign sh_dec  = sh - {{(SHW-1){1'b0}}, 1'b1};
  // WIDTH-sh modulo WIDTH: index of the last bit leaving the top
  assign sh_neg  = -sh;
  assign sh_comp = {1'b1, {SHW{1'b0}}} - {1'b0, sh};

  always_comb begin
    shift_res   = '0;
    shift_carry = 1'b0;
    shift_ill   = 1'b0;
    case (s1_op_reg)
      OP_SLL: begin
        shift_res   = s1_a_reg << sh;
        shift_carry = sh_nz && s1_a_reg[sh_neg];
      end
      OP_SRL: begin
        shift_res   = s1_a_reg >> sh;
        shift_carry = sh_nz && s1_a_reg[sh_dec];
      end
      OP_SRA: begin
        shift_res   = $signed(s1_a_reg) >>> sh;
        shift_carry = sh_nz && s1_a_reg[sh_dec];
      end
      OP_ROL: begin
        shift_res   = (s1_a_reg << sh) | (s1_a_reg >> sh_comp);
        shift_carry = sh_nz && s1_a_reg[sh_neg];
      end
      OP_ROR: begin
        shift_res   = (s1_a_reg >> sh) | (s1_a_reg << sh_comp);
        shift_carry = sh_nz && s1_a_reg[sh_dec];
      end
      default: shift_ill = 1'b1;
    endcase
  end

  // ---------------- unit select ----------------
  logic [WIDTH-1:0] res_next;
  logic             carry_next;
  logic             ovf_next;
  logic             ill_next;
  logic             zero_next;

  always_comb begin
    res_next   = arith_res;
    carry_next = arith_carry;
    ovf_next   = arith_ovf;
    ill_next   = 1'b0;
    if (s1_unit_reg) begin
      res_next   = shift_res;
      carry_next = shift_carry;
      ovf_next   = 1'b0;
      ill_next   = shift_ill;
    end
  end

  assign zero_next = (res_next == '0);

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_unit_reg  <= 1'b0;
      s1_op_reg    <= '0;
      s2_valid_reg <= 1'b0;
      s2_res_reg   <= '0;
      s2_zero_reg  <= 1'b0;
      s2_carry_reg <= 1'b0;
      s2_ovf_reg   <= 1'b0;
      s2_ill_reg   <= 1'b0;
      op_count_reg <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_a_reg    <= aluin1;
          s1_b_reg    <= aluin2;
          s1_unit_reg <= unit_sel;
          s1_op_reg   <= operation;
        end
      end
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_res_reg   <= res_next;
          s2_zero_reg  <= zero_next;
          s2_carry_reg <= carry_next;
          s2_ovf_reg   <= ovf_next;
          s2_ill_reg   <= ill_next;
        end
      end
      if (s2_valid_reg && out_ready) begin
        op_count_reg <= op_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid   = s2_valid_reg;
  assign aluout      = s2_res_reg;
  assign flag_zero   = s2_zero_reg;
  assign flag_carry  = s2_carry_reg;
  assign flag_ovf    = s2_ovf_reg;
  assign err_illegal = s2_ill_reg;
  assign op_count    = op_count_reg;

endmodule
